// File: rtl/vga_timing_gen.sv
// 800x600@72Hz raster timing from the 100 MHz board clock, plus frame and game-rate ticks.
// All outputs are registered from the next counter state on each pixel advance, so they always agree.
module vga_timing_gen #(
  parameter int CLK_DIV           = 2,
  parameter int H_VISIBLE         = 800,
  parameter int H_FP              = 56,
  parameter int H_SYNC            = 120,
  parameter int H_BP              = 64,
  parameter int V_VISIBLE         = 600,
  parameter int V_FP              = 37,
  parameter int V_SYNC            = 6,
  parameter int V_BP              = 23,
  parameter bit HS_POL            = 1'b1,
  parameter bit VS_POL            = 1'b1,
  parameter int FRAMES_PER_UPDATE = 6
) (
  input  logic       CLK_100MHz,
  input  logic       reset,
  input  logic       pause,
  output logic [9:0] CurrentX,
  output logic [9:0] CurrentY,
  output logic       displayArea,
  output logic       HS,
  output logic       VS,
  output logic       pix_en,
  output logic       frame_tick,
  output logic       update_tick
);

  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW       = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

  logic [PW-1:0] phase;
  logic [10:0]   hcnt;
  logic [9:0]    vcnt;
  logic [FW-1:0] fcnt;

  logic          pixStep;
  logic          lineWrap;
  logic          frameWrap;
  logic [10:0]   hNext;
  logic [9:0]    vNext;
  logic          daNext;
  logic          hsNext;
  logic          vsNext;

  assign pixStep   = (phase == PW'(CLK_DIV - 1));
  assign lineWrap  = (hcnt == 11'(H_TOTAL - 1));
  assign frameWrap = lineWrap && (vcnt == 10'(V_TOTAL - 1));
  assign hNext     = lineWrap ? 11'd0 : hcnt + 11'd1;
  assign vNext     = frameWrap ? 10'd0 : (lineWrap ? vcnt + 10'd1 : vcnt);
  assign daNext    = (hNext < 11'(H_VISIBLE)) && (vNext < 10'(V_VISIBLE));
  assign hsNext    = (hNext >= 11'(HS_START)) && (hNext < 11'(HS_END));
  assign vsNext    = (vNext >= 10'(VS_START)) && (vNext < 10'(VS_END));

  always_ff @(posedge CLK_100MHz or negedge reset) begin
    if (!reset) begin
      phase       <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      fcnt        <= '0;
      CurrentX    <= '0;
      CurrentY    <= '0;
      displayArea <= 1'b1;
      HS          <= ~HS_POL;
      VS          <= ~VS_POL;
      pix_en      <= 1'b0;
      frame_tick  <= 1'b0;
      update_tick <= 1'b0;
    end else begin
      phase       <= pixStep ? '0 : phase + 1'b1;
      pix_en      <= pixStep;
      frame_tick  <= 1'b0;
      update_tick <= 1'b0;
      if (pixStep) begin
        hcnt        <= hNext;
        vcnt        <= vNext;
        displayArea <= daNext;
        CurrentX    <= daNext ? hNext[9:0] : 10'd0;
        CurrentY    <= daNext ? vNext : 10'd0;
        HS          <= hsNext ? HS_POL : ~HS_POL;
        VS          <= vsNext ? VS_POL : ~VS_POL;
        // pause only freezes the game-rate divider; the raster keeps running
        if (frameWrap) begin
          frame_tick <= 1'b1;
          if (!pause) begin
            if (fcnt == FW'(FRAMES_PER_UPDATE - 1)) begin
              fcnt        <= '0;
              update_tick <= 1'b1;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
